// File: rtl/wb_ram_ws_if.sv
// Wishbone classic-cycle bus bundle between the stream bridge master
// and the wait-state RAM slave.
interface wb_ram_ws_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_ram_ws.sv
// Wishbone classic slave RAM with byte lanes, programmable wait states
// and an error response for addresses beyond the memory depth.
module wb_ram_ws #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WAIT_STATES    = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_ram_ws_if.slave wb
);

  localparam int OFF   = $clog2(SELECT_WIDTH);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        ack_q;
  logic                        err_q;
  logic [DATA_WIDTH-1:0]       rdat_q;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];

  logic                        req;
  logic                        enter;
  logic                        in_range;
  logic [MEM_ADDR_WIDTH-1:0]   idx;
  logic                        unused_adr;

  assign req      = wb.cyc & wb.stb;
  assign idx      = wb.adr[MEM_ADDR_WIDTH+OFF-1:OFF];
  assign in_range = (wb.adr >> (MEM_ADDR_WIDTH + OFF)) == '0;
  assign unused_adr = ^wb.adr;

  // Edge on which the response is registered and the write committed.
  assign enter =
    req &&
    (((state_q == S_IDLE) && (WAIT_STATES == 0)) ||
     ((state_q == S_WAIT) && (cnt_q == 4'd0)));

  // Next-state and wait-counter decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state, counter and registered ack/err/read-data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter & in_range;
      err_q   <= enter & ~in_range;
      if (enter) begin
        if (!in_range) begin
          rdat_q <= '0;
        end else if (!wb.we) begin
          rdat_q <= mem[idx];
        end
      end
    end
  end

  // Byte-lane write, suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && enter && in_range && wb.we) begin
      for (int k = 0; k < SELECT_WIDTH; k++) begin
        if (wb.sel[k]) begin
          mem[idx][8*k +: 8] <= wb.dat_w[8*k +: 8];
        end
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_r = rdat_q;

endmodule
